mat_row_streamer: RTL and testbench
===================================

MAT_ROW_STREAMER -- requirements
Module: mat_row_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of one matrix element in bits.
REQ-002 SHALL have parameter ROW_IN, default 8, the number of rows per matrix (ROW_IN >= 2).
REQ-003 SHALL have parameter COL_IN, default 8, the number of elements per row.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1 bit, synchronous abort of the current matrix.
REQ-007 SHALL have port in_valid, input, 1 bit, upstream matrix valid.
REQ-008 SHALL have port in_ready, output, 1 bit, block can accept a matrix.
REQ-009 SHALL have port in_mat, input, DATA_WIDTH*ROW_IN*COL_IN bits, flattened matrix; element (i,j) at bit offset DATA_WIDTH*(i*COL_IN+j), row 0 in the LSBs.
REQ-010 SHALL have port out_valid, output, 1 bit, row beat valid.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the row.
REQ-012 SHALL have port out_row, output, DATA_WIDTH*COL_IN bits, current row, element j at offset DATA_WIDTH*j.
REQ-013 SHALL have port out_row_idx, output, ROW_W=max(1,clog2(ROW_IN)) bits, index of the current row.
REQ-014 SHALL have port out_last, output, 1 bit, high when out_row_idx == ROW_IN-1 and out_valid is high.

Function
REQ-015 SHALL implement the FSM states IDLE (no matrix held) and SEND (matrix held, rows being streamed).
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==SEND && out_last && out_ready && !clear).
REQ-017 SHALL, on an input handshake (in_valid && in_ready) at edge N, capture in_mat into an internal buffer, set the row index to 0 and enter SEND; out_valid SHALL be high from cycle N+1 (one-cycle latency).
REQ-018 SHALL hold out_valid high in SEND and low in IDLE.
REQ-019 SHALL drive out_row from buffer row out_row_idx, with no added latency relative to the index.
REQ-020 SHALL keep out_row, out_row_idx and out_last stable while out_valid && !out_ready.
REQ-021 SHALL, on an output handshake with out_row_idx < ROW_IN-1, increment the index by 1.
REQ-022 SHALL, on an output handshake on the last row with no input handshake in the same cycle, return to IDLE with the index reset to 0.
REQ-023 SHALL, when a last-row output handshake and an input handshake occur in the same cycle, capture the new matrix and stay in SEND at index 0, with no bubble cycle.
REQ-024 SHALL ignore in_valid while in SEND except on the last row as defined in REQ-016; the buffer SHALL NOT change in that case.
REQ-025 SHALL, when clear is high, go to IDLE with the index at 0 on the next edge, discard any remaining rows and accept no input that cycle; clear SHALL take priority over all handshakes.
REQ-026 SHALL store data bit-exactly, with no arithmetic applied; rows SHALL emit in order 0 to ROW_IN-1.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force state=IDLE, index=0, buffer=0 and out_valid=0, so that out_row=0 and out_last=0.
REQ-028 SHALL present in_ready=1 after reset deassertion; a reset asserted mid-stream SHALL drop the matrix with no further beats.

Structure
REQ-029 SHALL take the state encoding (IDLE=0, SEND=1) and the ROW_W width function from shared package mat_stream_pkg, which a future matching row collector will reuse.
REQ-030 SHALL instantiate one sub-module, mat_row_select, a combinational ROW_IN:1 mux that selects a row from the flattened buffer; the FSM, counter and buffer SHALL stay in the top module.

Verification (DATA_WIDTH=16, ROW_IN=2, COL_IN=2)
REQ-031 Single matrix: in_mat=0x0004_0003_0002_0001, out_ready=1 -> beats 0x0002_0001 (idx0, last=0) then 0x0004_0003 (idx1, last=1); IDLE on the following cycle.
REQ-032 Backpressure: out_ready=0 for 3 cycles on row 0 -> out_row held at 0x0002_0001 and idx=0 throughout, in_ready=0.
REQ-033 Back-to-back: second matrix 0x0008_0007_0006_0005 offered during the last-row handshake -> next beat 0x0006_0005 with idx=0 in the immediately following cycle, no gap.
REQ-034 Clear: clear pulsed after the row 0 handshake -> no row 1 beat, out_valid=0 next cycle, in_ready=1.
REQ-035 Reset: rst_n dropped mid-SEND -> out_valid=0 and out_row=0 immediately without a clock edge; after release the first beat is row 0 of a newly supplied matrix.

Source files
------------

// File: rtl/mat_stream_pkg.sv
// Shared definitions for the matrix row streaming blocks.
//   state_t : FSM state encoding (IDLE = 0, SEND = 1)
//   row_w() : width of a row index for a given row count, never below 1 bit
package mat_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/mat_row_select.sv
// Combinational ROW_IN:1 row multiplexer over a flattened matrix.
//   mat : flattened matrix, element (i,j) at DATA_WIDTH*(i*COL_IN+j)
//   sel : row index
//   row : selected row, element j at DATA_WIDTH*j (zero if sel is out of range)
module mat_row_select #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_IN     = 8,
    parameter int COL_IN     = 8,
    parameter int ROW_W      = 3
) (
    input  logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] mat,
    input  logic [ROW_W-1:0]                    sel,
    output logic [DATA_WIDTH*COL_IN-1:0]        row
);

    localparam int ROW_BITS = DATA_WIDTH * COL_IN;

    logic [ROW_BITS-1:0] rows [ROW_IN];

    for (genvar gi = 0; gi < ROW_IN; gi++) begin : g_rows
        assign rows[gi] = mat[gi*ROW_BITS +: ROW_BITS];
    end

    // Compare-and-select rather than rows[sel] so a non-power-of-two
    // ROW_IN never indexes past the array.
    always_comb begin
        row = '0;
        for (int i = 0; i < ROW_IN; i++) begin
            if (sel == ROW_W'(i)) begin
                row = rows[i];
            end
        end
    end

endmodule

// File: rtl/mat_row_streamer.sv
// Accepts a whole matrix in one handshake and streams it out one row per
// beat, rows 0..ROW_IN-1, with valid/ready on both sides.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous abort of the held matrix (beats all handshakes)
//   in_valid/ready  : matrix input handshake, in_mat flattened matrix
//   out_valid/ready : row output handshake
//   out_row         : current row, out_row_idx its index, out_last on final row
module mat_row_streamer
    import mat_stream_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int ROW_IN     = 8,
    parameter  int COL_IN     = 8,
    localparam int ROW_W      = row_w(ROW_IN)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] in_mat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH*COL_IN-1:0]        out_row,
    output logic [ROW_W-1:0]                    out_row_idx,
    output logic                                out_last
);

    localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ROW_IN - 1);

    state_t                              state_reg, state_next;
    logic [ROW_W-1:0]                    idx_reg, idx_next;
    logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] buf_reg;
    logic                                load;

    assign out_valid   = (state_reg == SEND);
    assign out_row_idx = idx_reg;
    assign out_last    = out_valid && (idx_reg == LAST_IDX);

    // Accepting on the last-row handshake lets a new matrix follow with no
    // bubble; clear suppresses that early acceptance.
    assign in_ready = (state_reg == IDLE) ||
                      ((state_reg == SEND) && out_last && out_ready && !clear);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        if (clear) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = SEND;
                        idx_next   = '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            idx_next = '0;
                            if (in_valid) begin
                                load       = 1'b1;
                                state_next = SEND;
                            end else begin
                                state_next = IDLE;
                            end
                        end else begin
                            idx_next = idx_reg + ROW_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (load) begin
                buf_reg <= in_mat;
            end
        end
    end

    mat_row_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_IN     (ROW_IN),
        .COL_IN     (COL_IN),
        .ROW_W      (ROW_W)
    ) u_row_select (
        .mat (buf_reg),
        .sel (idx_reg),
        .row (out_row)
    );

endmodule

// File: tb/tb_mat_row_streamer.sv
module tb_mat_row_streamer;

    localparam int DW   = 16;
    localparam int RI   = 2;
    localparam int CI   = 2;
    localparam int MW   = DW * RI * CI;
    localparam int RWID = DW * CI;

    typedef struct {
        logic [RWID-1:0] row;
        int              idx;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [MW-1:0]   in_mat = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RWID-1:0] out_row;
    logic [0:0]      out_row_idx;
    logic            out_last;

    int n_tests = 0;
    int n_fail  = 0;
    int n_beats = 0;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    mat_row_streamer #(
        .DATA_WIDTH (DW),
        .ROW_IN     (RI),
        .COL_IN     (CI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mat      (in_mat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a matrix becomes the ordered list of its rows; the
    // block is ready when nothing is held, or the final held row is leaving.
    function automatic bit model_ready();
        return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready && !clear);
    endfunction

    initial begin : model
        forever begin : step
            bit    rdy;
            beat_t b;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                rdy = model_ready();
                if (clear) begin
                    exp_q.delete();
                end else begin
                    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                    if (in_valid && rdy) begin
                        for (int i = 0; i < RI; i++) begin
                            b.idx = i;
                            for (int j = 0; j < CI; j++)
                                b.row[j*DW +: DW] = in_mat[DW*(i*CI+j) +: DW];
                            exp_q.push_back(b);
                        end
                    end
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(model_ready()));
            if (exp_q.size() > 0) begin
                check("out_row", 64'(out_row), 64'(exp_q[0].row));
                check("out_row_idx", 64'(out_row_idx), 64'(exp_q[0].idx));
                check("out_last", 64'(out_last), 64'(exp_q[0].idx == RI - 1));
                if (out_valid && out_ready) begin
                    n_beats++;
                    $display("[TB] beat idx=%0d row=%h last=%0d", out_row_idx, out_row, out_last);
                end
            end else begin
                check("out_last_idle", 64'(out_last), 64'd0);
            end
        end
    end

    task automatic drive(input logic iv, input logic [MW-1:0] m, input logic ordy, input logic clr);
        in_valid  = iv;
        in_mat    = m;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int k = 0; k < RI * CI; k++) m[k*DW +: DW] = DW'($urandom);
        return m;
    endfunction

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [MW-1:0] m1, m2, m3;
        m1 = 64'h0004_0003_0002_0001;
        m2 = 64'h0008_0007_0006_0005;
        m3 = 64'h00dd_00cc_00bb_00aa;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_row", 64'(out_row), 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single matrix, continuous ready
        drive(1'b1, m1, 1'b1, 1'b0);
        check("single_row0", 64'(out_row), 64'h0000_0000_0002_0001);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("single_row1", 64'(out_row), 64'h0000_0000_0004_0003);
        check("single_last", 64'(out_last), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("single_idle", 64'(out_valid), 64'd0);

        // Backpressure on row 0 for 3 cycles
        drive(1'b1, m1, 1'b0, 1'b0);
        repeat (3) begin
            drive(1'b1, m2, 1'b0, 1'b0);
            check("bp_row_held", 64'(out_row), 64'h0000_0000_0002_0001);
            check("bp_idx_held", 64'(out_row_idx), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back matrices, new one offered on the last-row handshake
        drive(1'b1, m1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, m2, 1'b1, 1'b0);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_row", 64'(out_row), 64'h0000_0000_0006_0005);
        check("b2b_idx", 64'(out_row_idx), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Clear after the row 0 handshake
        drive(1'b1, m1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, m2, 1'b1, 1'b1);
        check("clear_valid", 64'(out_valid), 64'd0);
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clear_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        drive(1'b1, m2, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_row", 64'(out_row), 64'd0);
        check("arst_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, m3, 1'b1, 1'b0);
        check("arst_first_row", 64'(out_row), 64'h0000_0000_00bb_00aa);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 1) == 1), rand_mat(),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        n_tests++;
        if (n_beats < 50) begin
            n_fail++;
            $display("[TB] FAIL beat_count: got %0d expected at least 50", n_beats);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
